minesweeper_top: RTL and testbench

- Top-level controller for a 5x5 (25-cell) Minesweeper game.
- Places mines pseudo-randomly with an LCG, accepts cell selections and decodes them to a one-hot cell mask.
- Checks each selection against the mine map, updates the cleared map and score, and detects game-over or win.
- All internal state and debug signals are exported for bench and chip-level observation.

---
 rtl/minesweeper_top.sv | 223 ++++++++++++++++++++++
 tb/tb_minesweeper_top.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/minesweeper_top.sv
// 5x5 Minesweeper controller: LCG mine placement, cell decode, hit/clear scoring, win/lose detection.
// Define DIAG_NEIGHBOR_EN to count all 8 neighbours in out_n_nearby (default: 4 orthogonal only).
module minesweeper_top #(
    parameter int unsigned CELLS = 25,
    parameter int unsigned IDX_W = 5
) (
    input  logic               in_clka,
    input  logic               in_restart,
    input  logic               in_place,
    input  logic               in_data_in,
    input  logic [IDX_W-1:0]   in_data,
    input  logic [IDX_W-1:0]   in_mult,
    input  logic [IDX_W-1:0]   in_increment,
    input  logic [IDX_W-1:0]   in_modulus,
    input  logic [IDX_W-1:0]   in_mines_num,
    output logic [3:0]         out_state_main,
    output logic               out_start,
    output logic               out_place_done,
    output logic               out_load,
    output logic               out_decode,
    output logic               out_decode_done,
    output logic               out_alu,
    output logic               out_alu_done,
    output logic               out_display,
    output logic               out_display_done,
    output logic [CELLS-1:0]   out_mines,
    output logic [IDX_W-1:0]   out_temp_data_in,
    output logic               out_gameover,
    output logic               out_win,
    output logic [31:0]        out_global_score,
    output logic [1:0]         out_n_nearby,
    output logic [CELLS-1:0]   out_temp_decoded,
    output logic [CELLS-1:0]   out_temp_cleared
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_GEN = 4'd1, S_WAIT = 4'd2, S_LOAD = 4'd3, S_DECODE = 4'd4,
        S_ALU = 4'd5, S_DISPLAY = 4'd6, S_GAMEOVER = 4'd7, S_WIN = 4'd8
    } state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   seed, seed_d, mine_cnt, mine_cnt_d, data_d;
    logic [CELLS-1:0]   mines_d, decoded_d, cleared_d, place_mask;
    logic [31:0]        score_d;
    logic [1:0]         nearby_d, nearby_c;
    logic               gameover_d, win_d, start_d, place_done_d, decode_done_d, alu_done_d;
    logic               restart_c;
    logic [9:0]         lcg_full, mod_eff;
    logic [IDX_W-1:0]   lcg_next, mines_lim;

    assign out_state_main = state;
    assign restart_c = in_place && (state == S_IDLE || state == S_WAIT ||
                                    state == S_GAMEOVER || state == S_WIN);

    // LCG step and placement target: first free cell at or above lcg_next, wrapping
    always_comb begin
        logic [5:0]       cand;
        logic             found;
        mod_eff   = (in_modulus == '0 || in_modulus > IDX_W'(25)) ? 10'd25 : 10'(in_modulus);
        mines_lim = (in_mines_num > IDX_W'(24)) ? IDX_W'(24) : in_mines_num;
        lcg_full  = 10'(seed) * 10'(in_mult) + 10'(in_increment);
        lcg_next  = IDX_W'(lcg_full % mod_eff);
        place_mask = '0;
        found      = 1'b0;
        for (int k = 0; k < int'(CELLS); k++) begin
            cand = 6'(lcg_next) + 6'(k);
            if (cand >= 6'(CELLS)) cand = cand - 6'(CELLS);
            if (!found && !out_mines[IDX_W'(cand)]) begin
                place_mask[IDX_W'(cand)] = 1'b1;
                found = 1'b1;
            end
        end
    end

    // Adjacent-mine count around the latched cell, saturating at 3
    always_comb begin
        int r, c, nr, nc, cnt;
        r   = int'(out_temp_data_in) / 5;
        c   = int'(out_temp_data_in) % 5;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                nr = r + dr;
                nc = c + dc;
`ifdef DIAG_NEIGHBOR_EN
                if (!(dr == 0 && dc == 0) && nr >= 0 && nr < 5 && nc >= 0 && nc < 5)
`else
                if ((dr == 0) != (dc == 0) && nr >= 0 && nr < 5 && nc >= 0 && nc < 5)
`endif
                    if (out_mines[IDX_W'(nr * 5 + nc)]) cnt = cnt + 1;
            end
        end
        nearby_c = (cnt > 3) ? 2'd3 : 2'(cnt);
    end

    // Next-state and next-register values
    always_comb begin
        state_d       = state;
        seed_d        = seed;
        mine_cnt_d    = mine_cnt;
        data_d        = out_temp_data_in;
        mines_d       = out_mines;
        decoded_d     = out_temp_decoded;
        cleared_d     = out_temp_cleared;
        score_d       = out_global_score;
        nearby_d      = out_n_nearby;
        gameover_d    = out_gameover;
        win_d         = out_win;
        start_d       = 1'b0;
        place_done_d  = 1'b0;
        decode_done_d = 1'b0;
        alu_done_d    = 1'b0;
        case (state)
            S_GEN: begin
                if (mine_cnt == mines_lim) begin
                    place_done_d = 1'b1;
                    state_d      = S_WAIT;
                end else begin
                    seed_d     = lcg_next;
                    mines_d    = out_mines | place_mask;
                    mine_cnt_d = mine_cnt + IDX_W'(1);
                end
            end
            S_WAIT: begin
                if (!restart_c && in_data_in) begin
                    data_d  = in_data;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: state_d = S_DECODE;
            S_DECODE: begin
                if (out_temp_data_in > IDX_W'(CELLS - 1)) begin
                    decoded_d = '0;
                    state_d   = S_WAIT;
                end else begin
                    decoded_d     = CELLS'(1) << out_temp_data_in;
                    decode_done_d = 1'b1;
                    state_d       = S_ALU;
                end
            end
            S_ALU: begin
                if (|(out_temp_decoded & out_mines)) begin
                    gameover_d = 1'b1;
                    state_d    = S_GAMEOVER;
                end else begin
                    cleared_d = out_temp_cleared | out_temp_decoded;
                    if (!(|(out_temp_decoded & out_temp_cleared)))
                        score_d = out_global_score + 32'd1;
                    nearby_d   = nearby_c;
                    alu_done_d = 1'b1;
                    state_d    = S_DISPLAY;
                end
            end
            S_DISPLAY: begin
                if (&(out_temp_cleared | out_mines)) begin
                    win_d   = 1'b1;
                    state_d = S_WIN;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: ;
        endcase
        if (restart_c) begin
            mines_d    = '0;
            cleared_d  = '0;
            score_d    = '0;
            nearby_d   = '0;
            mine_cnt_d = '0;
            gameover_d = 1'b0;
            win_d      = 1'b0;
            start_d    = 1'b1;
            state_d    = S_GEN;
        end
    end

    always_ff @(posedge in_clka or negedge in_restart) begin
        if (!in_restart) begin
            state            <= S_IDLE;
            seed             <= '0;
            mine_cnt         <= '0;
            out_start        <= 1'b0;
            out_place_done   <= 1'b0;
            out_load         <= 1'b0;
            out_decode       <= 1'b0;
            out_decode_done  <= 1'b0;
            out_alu          <= 1'b0;
            out_alu_done     <= 1'b0;
            out_display      <= 1'b0;
            out_display_done <= 1'b0;
            out_mines        <= '0;
            out_temp_data_in <= '0;
            out_gameover     <= 1'b0;
            out_win          <= 1'b0;
            out_global_score <= '0;
            out_n_nearby     <= '0;
            out_temp_decoded <= '0;
            out_temp_cleared <= '0;
        end else begin
            state            <= state_d;
            seed             <= seed_d;
            mine_cnt         <= mine_cnt_d;
            out_start        <= start_d;
            out_place_done   <= place_done_d;
            out_load         <= (state_d == S_LOAD);
            out_decode       <= (state_d == S_DECODE);
            out_decode_done  <= decode_done_d;
            out_alu          <= (state_d == S_ALU);
            out_alu_done     <= alu_done_d;
            out_display      <= (state_d == S_DISPLAY);
            out_display_done <= (state_d == S_DISPLAY);
            out_mines        <= mines_d;
            out_temp_data_in <= data_d;
            out_gameover     <= gameover_d;
            out_win          <= win_d;
            out_global_score <= score_d;
            out_n_nearby     <= nearby_d;
            out_temp_decoded <= decoded_d;
            out_temp_cleared <= cleared_d;
        end
    end

endmodule

// File: tb/tb_minesweeper_top.sv
// Directed bench for minesweeper_top: reset, mine placement, selection table, game over, win.
module tb_minesweeper_top;

    logic        clk = 1'b0;
    logic        rst_n, place, data_in;
    logic [4:0]  data, mult, incr, modulus, mines_num;
    logic [3:0]  state_main;
    logic        start, place_done, load, decode, decode_done, alu, alu_done, display, display_done;
    logic [24:0] mines, decoded, cleared;
    logic [4:0]  tdata;
    logic        gameover, win;
    logic [31:0] score;
    logic [1:0]  nearby;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    minesweeper_top dut (
        .in_clka(clk), .in_restart(rst_n), .in_place(place), .in_data_in(data_in),
        .in_data(data), .in_mult(mult), .in_increment(incr), .in_modulus(modulus),
        .in_mines_num(mines_num), .out_state_main(state_main), .out_start(start),
        .out_place_done(place_done), .out_load(load), .out_decode(decode),
        .out_decode_done(decode_done), .out_alu(alu), .out_alu_done(alu_done),
        .out_display(display), .out_display_done(display_done), .out_mines(mines),
        .out_temp_data_in(tdata), .out_gameover(gameover), .out_win(win),
        .out_global_score(score), .out_n_nearby(nearby), .out_temp_decoded(decoded),
        .out_temp_cleared(cleared)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  idx;
        logic [3:0]  st;
        logic [24:0] dec;
        logic [24:0] clr;
        logic [31:0] score;
        logic [1:0]  nb;
        logic        go;
        logic        win;
    } sel_t;

    sel_t vec [6];

    task automatic do_select(input sel_t v);
        int n;
        data    = v.idx;
        data_in = 1'b1;
        @(negedge clk);
        data_in = 1'b0;
        chk("load_state", 32'(state_main), 32'd3);
        chk("load_flag", 32'(load), 32'd1);
        n = 0;
        while (!(state_main == 4'd2 || state_main == 4'd7 || state_main == 4'd8) && n < 12) begin
            @(negedge clk);
            n++;
        end
        if (n >= 12) begin
            total++;
            bad++;
            $display("FAIL select_timeout idx=%0d state=%0d", v.idx, state_main);
        end
        chk("sel_state", 32'(state_main), 32'(v.st));
        chk("sel_decoded", 32'(decoded), 32'(v.dec));
        chk("sel_cleared", 32'(cleared), 32'(v.clr));
        chk("sel_score", score, v.score);
        chk("sel_nearby", 32'(nearby), 32'(v.nb));
        chk("sel_gameover", 32'(gameover), 32'(v.go));
        chk("sel_win", 32'(win), 32'(v.win));
    endtask

    initial begin
        int n;
        vec[0] = '{5'd2,  4'd2, 25'h4,   25'h4,   32'd1, 2'd1, 1'b0, 1'b0};
        vec[1] = '{5'd5,  4'd2, 25'h20,  25'h24,  32'd2, 2'd1, 1'b0, 1'b0};
        vec[2] = '{5'd5,  4'd2, 25'h20,  25'h24,  32'd2, 2'd1, 1'b0, 1'b0};
        vec[3] = '{5'd6,  4'd7, 25'h40,  25'h24,  32'd2, 2'd1, 1'b1, 1'b0};
        vec[4] = '{5'd27, 4'd2, 25'h0,   25'h0,   32'd0, 2'd0, 1'b0, 1'b0};
        vec[5] = '{5'd9,  4'd8, 25'h200, 25'h200, 32'd1, 2'd3, 1'b0, 1'b1};

        rst_n = 1'b0; place = 1'b0; data_in = 1'b0; data = '0;
        mult = 5'd1; incr = 5'd3; modulus = 5'd25; mines_num = 5'd10;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state_main), 32'd0);
        chk("rst_mines", 32'(mines), 32'd0);
        chk("rst_score", score, 32'd0);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of mine generation
        @(negedge clk); place = 1'b1;
        @(negedge clk); place = 1'b0;
        chk("gen_enter", 32'(state_main), 32'd1);
        @(posedge clk); #2 rst_n = 1'b0; #1;
        chk("async_state", 32'(state_main), 32'd0);
        chk("async_mines", 32'(mines), 32'd0);
        chk("async_start", 32'(start), 32'd0);
        @(negedge clk); rst_n = 1'b1; mines_num = 5'd3;

        // Placement 3, 6, 9 from seed 0
        @(negedge clk); place = 1'b1;
        @(negedge clk); place = 1'b0;
        chk("start_pulse", 32'(start), 32'd1);
        chk("gen_state", 32'(state_main), 32'd1);
        @(negedge clk); chk("gen_m1", 32'(mines), 32'h8);
        chk("start_low", 32'(start), 32'd0);
        @(negedge clk); chk("gen_m2", 32'(mines), 32'h48);
        @(negedge clk); chk("gen_m3", 32'(mines), 32'h248);
        chk("gen_m3_state", 32'(state_main), 32'd1);
        @(negedge clk);
        chk("wait_state", 32'(state_main), 32'd2);
        chk("place_done", 32'(place_done), 32'd1);
        chk("wait_mines", 32'(mines), 32'h248);
        @(negedge clk); chk("place_done_low", 32'(place_done), 32'd0);

        for (int i = 0; i < 4; i++) do_select(vec[i]);

        // New game from GAMEOVER: 24 mines, modulus 0 treated as 25, seed continues at 9
        place = 1'b1; mines_num = 5'd24; modulus = 5'd0;
        @(negedge clk); place = 1'b0;
        chk("ng_state", 32'(state_main), 32'd1);
        chk("ng_gameover", 32'(gameover), 32'd0);
        chk("ng_cleared", 32'(cleared), 32'd0);
        chk("ng_score", score, 32'd0);
        n = 0;
        while (state_main != 4'd2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL gen24_timeout state=%0d", state_main);
        end
        chk("gen24_mines", 32'(mines), 32'h1FFFDFF);
        chk("gen24_done", 32'(place_done), 32'd1);

        for (int i = 4; i < 6; i++) do_select(vec[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
